// File: rtl/aurora_pkg.sv
// Shared types and defaults for the Aurora channel-initialisation logic.
// The ordered-set request vector and the channel init state live here.
package aurora_pkg;

    localparam int LANES_DEF   = 4;
    localparam int VER_CNT_DEF = 4;
    localparam int TIMEOUT_DEF = 1024;
    localparam int RETRY_W_DEF = 4;

    typedef struct packed {
        logic sp;
        logic spa;
        logic i;
        logic ver;
        logic cc;
        logic k;
        logic r;
        logic a;
    } ordered_sets_t;

    typedef enum logic [2:0] {
        CI_RESET        = 3'd0,
        CI_INIT         = 3'd1,
        CI_BONDING      = 3'd2,
        CI_VERIFICATION = 3'd3,
        CI_READY        = 3'd4
    } chan_init_state_e;

    // READY and any illegal encoding request no ordered sets at all.
    function automatic ordered_sets_t os_for_state(input chan_init_state_e s);
        ordered_sets_t os;
        os = '0;
        case (s)
            CI_RESET, CI_INIT: os.sp  = 1'b1;
            CI_BONDING:        os.i   = 1'b1;
            CI_VERIFICATION:   os.ver = 1'b1;
            default:           os     = '0;
        endcase
        return os;
    endfunction

endpackage

// File: rtl/init_watchdog.sv
// Per-state dwell counter: counts cycles since the last clear and
// saturates on the terminal count, where expired stays high.
module init_watchdog
    import aurora_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/lane_channel_init.sv
// Channel bring-up sequencer: RESET -> INIT -> (BONDING) -> VERIFICATION -> READY,
// with a per-state watchdog, retry counting and registered outputs.
module lane_channel_init
    import aurora_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int VER_CNT = VER_CNT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int RETRY_W = RETRY_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                simplex_reset,
    input  logic [LANES-1:0]    lane_mask,
    input  logic [LANES-1:0]    lane_aligned,
    input  logic [LANES-1:0]    lane_bonded,
    input  logic [LANES-1:0]    lane_verified,
    output ordered_sets_t       ordered_sets,
    output logic                init_finished,
    output logic [LANES-1:0]    lane_up,
    output logic                timeout_err,
    output logic [RETRY_W-1:0]  retry_cnt
);

    localparam logic [7:0]         VER_LAST  = 8'(VER_CNT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    chan_init_state_e   state;
    chan_init_state_e   next_state;
    logic [7:0]         ver_cnt;
    logic [7:0]         ver_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [LANES-1:0]   mask_q;
    logic               tmo_nxt;
    logic               wd_clear;
    logic               wd_expired;
    logic               aligned_ok;
    logic               bonded_ok;
    logic               verified_ok;
    logic               multi_lane;
    logic               mask_changed;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic more_than_one(input logic [LANES-1:0] m);
        return (m & (m - LANES'(1))) != '0;
    endfunction

    init_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    always_comb begin
        aligned_ok   = ((lane_aligned  & lane_mask) == lane_mask);
        bonded_ok    = ((lane_bonded   & lane_mask) == lane_mask);
        verified_ok  = ((lane_verified & lane_mask) == lane_mask);
        multi_lane   = more_than_one(lane_mask);
        mask_changed = (lane_mask != mask_q);

        next_state = state;
        ver_nxt    = ver_cnt;
        tmo_nxt    = 1'b0;

        case (state)
            CI_RESET: begin
                if (lane_mask != '0) next_state = CI_INIT;
            end
            CI_INIT: begin
                if (aligned_ok) begin
                    next_state = multi_lane ? CI_BONDING : CI_VERIFICATION;
                end else if (wd_expired) begin
                    next_state = CI_RESET;
                    tmo_nxt    = 1'b1;
                end
            end
            CI_BONDING: begin
                if (bonded_ok) begin
                    next_state = CI_VERIFICATION;
                end else if (wd_expired) begin
                    next_state = CI_RESET;
                    tmo_nxt    = 1'b1;
                end
            end
            CI_VERIFICATION: begin
                if (verified_ok && (ver_cnt >= VER_LAST)) begin
                    next_state = CI_READY;
                end else begin
                    ver_nxt = verified_ok ? ver_cnt + 8'd1 : 8'd0;
                    if (wd_expired) begin
                        next_state = CI_RESET;
                        tmo_nxt    = 1'b1;
                    end
                end
            end
            CI_READY: begin
                if (!aligned_ok) next_state = CI_RESET;
            end
            default: begin
                next_state = CI_RESET;
            end
        endcase

        // A reconfigured lane set restarts bring-up without counting as a failure.
        if ((state != CI_RESET) && mask_changed) begin
            next_state = CI_RESET;
            tmo_nxt    = 1'b0;
        end

        if (simplex_reset) begin
            next_state = CI_RESET;
            tmo_nxt    = 1'b0;
        end

        if (next_state != CI_VERIFICATION) ver_nxt = '0;

        retry_nxt = retry_cnt;
        if (tmo_nxt && (retry_cnt != RETRY_MAX)) retry_nxt = retry_cnt + RETRY_W'(1);

        wd_clear = (next_state != state) || simplex_reset;
    end

    // Outputs are decoded from the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        mask_q <= lane_mask;
        if (rst) begin
            state         <= CI_RESET;
            ordered_sets  <= '0;
            init_finished <= 1'b0;
            lane_up       <= '0;
            timeout_err   <= 1'b0;
            retry_cnt     <= '0;
            ver_cnt       <= '0;
        end else begin
            state         <= next_state;
            ordered_sets  <= os_for_state(next_state);
            init_finished <= (next_state == CI_READY);
            lane_up       <= (next_state == CI_READY) ? lane_mask : '0;
            timeout_err   <= tmo_nxt;
            retry_cnt     <= retry_nxt;
            ver_cnt       <= ver_nxt;
        end
    end

endmodule
